game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
Top-level Asteroids game-flow controller. Tracks lives and sequences attract, play, respawn and game-over phases. Produces the 2-bit game-state code consumed by the GAME OVER text overlay and other screen/overlay logic. Also drives ship enable, the life count for the HUD, and a one-cycle reset pulse that clears score and asteroid field at new-game start.

Parameters:
LIVES, 3, lives loaded at new-game start (legal 1..7)
RESPAWN_FRAMES, 120, frame ticks spent in RESPAWN after a non-fatal hit (legal 1..255)
GAMEOVER_HOLD_FRAMES, 180, frame ticks in GAME_OVER before start is accepted (legal 0..255)

Ports:
iClk  in  1  system/pixel clock
iRst  in  1  asynchronous reset, active-low
iStart  in  1  start button, active-high level, asynchronous to iClk (top level inverts board key)
iShipHit  in  1  one-cycle pulse from collision detect: ship struck
iFrameTick  in  1  one-cycle pulse, once per VGA frame
oGameOver  out  2  state code: 00 PLAYING, 01 GAME_OVER, 10 ATTRACT, 11 RESPAWN
oLives  out  3  remaining lives
oShipEnable  out  1  high only in PLAYING
oGameReset  out  1  one-cycle pulse at new-game start

Behaviour:
- All outputs registered. On iRst low, async: state ATTRACT, oGameOver=10, oLives=0, oShipEnable=0, oGameReset=0, timer=0, synchronizer and edge flops=0.
- Start path: iStart -> sync1 -> sync2 -> prev. start_edge = sync2 & ~prev, combinational. iStart rising before clock edge n gives start_edge during the cycle after edge n+1. The state change registers on edge n+2. An edge is consumed in the cycle it occurs and never queued.
- ATTRACT:
  - start_edge -> PLAYING, oLives=LIVES, oGameReset=1 for exactly that one cycle.
  - iShipHit and iFrameTick ignored.
- PLAYING:
  - oShipEnable=1, oGameOver=00.
  - iShipHit with oLives>1 -> RESPAWN, oLives-1, timer=RESPAWN_FRAMES.
  - iShipHit with oLives==1 -> GAME_OVER, oLives=0, timer=GAMEOVER_HOLD_FRAMES.
  - start_edge ignored.
  - iShipHit and iFrameTick in the same cycle: the hit is processed and that tick is not counted.
- RESPAWN:
  - oShipEnable=0, oGameOver=11.
  - On iFrameTick: if timer==1 -> PLAYING, else timer-1.
  - The state therefore lasts exactly RESPAWN_FRAMES ticks. iShipHit and start_edge ignored.
- GAME_OVER:
  - oGameOver=01, oShipEnable=0.
  - On iFrameTick with timer!=0: timer-1. Timer saturates at 0.
  - start_edge with timer==0 -> PLAYING, oLives=LIVES, oGameReset pulse.
  - start_edge with timer!=0 is discarded. A held button does not re-trigger; a fresh rising edge is required.
  - start_edge and iFrameTick in the same cycle with timer==1: the tick decrements, the start is discarded.
- oGameReset is asserted in the same cycle oGameOver first reads 00 and lasts exactly one cycle.
- No other path reaches ATTRACT except reset. Unused state encodings recover to ATTRACT on the next clock.
- Timer is 8 bits wide. oLives never underflows.
- Async reset mid-RESPAWN or mid-GAME_OVER returns immediately to the reset values above, with no pulse on oGameReset.

Test Plan:
(Bench runs with LIVES=3, RESPAWN_FRAMES=4, GAMEOVER_HOLD_FRAMES=6.)
1. Assert iRst low, then release. Expect oGameOver=10, oLives=0, oShipEnable=0, oGameReset=0. Then raise iStart before edge n. Expect on edge n+2: oGameOver=00, oLives=3, oShipEnable=1, oGameReset=1 for one cycle only. Hold iStart high 100 cycles: no further pulse.
2. From PLAYING, one iShipHit pulse. Expect oGameOver=11, oLives=2, oShipEnable=0. After exactly 4 iFrameTick pulses, oGameOver=00 on the edge of the 4th. Hits injected during RESPAWN leave oLives=2.
3. In PLAYING, iShipHit and iFrameTick in the same cycle. Expect RESPAWN with a full 4-tick count.
4. Three separated hits across PLAYING phases. Expect oLives 3->2->1->0 and oGameOver=01 after the third. A start edge after 3 ticks: no change. After 6 ticks, a fresh start edge: oGameOver=00, oLives=3, single oGameReset pulse.
5. Drop iRst low mid-RESPAWN with timer=2. Expect immediate oGameOver=10, oLives=0, oShipEnable=0, no oGameReset. After release, normal start from ATTRACT.
6. In GAME_OVER with timer=1, start_edge coincident with iFrameTick. Expect start discarded, timer=0, state stays 01. The next start edge enters PLAYING.

Source files
------------

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_state_ctrl
// Purpose  : Asteroids game-flow controller: attract, play, respawn and
//            game-over sequencing, life tracking and new-game reset pulse.
// Revision : 1.0 - initial release
// ============================================================================
module game_state_ctrl #(
  parameter int LIVES                = 3,
  parameter int RESPAWN_FRAMES       = 120,
  parameter int GAMEOVER_HOLD_FRAMES = 180
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iShipHit,
  input  logic       iFrameTick,
  output logic [1:0] oGameOver,
  output logic [2:0] oLives,
  output logic       oShipEnable,
  output logic       oGameReset
);

  localparam logic [2:0] c_LIVES_INIT   = 3'(LIVES);
  localparam logic [7:0] c_RESPAWN_INIT = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] c_HOLD_INIT    = 8'(GAMEOVER_HOLD_FRAMES);

  // State encoding doubles as the oGameOver code seen by the overlays.
  typedef enum logic [1:0] {
    ST_PLAYING   = 2'b00,
    ST_GAME_OVER = 2'b01,
    ST_ATTRACT   = 2'b10,
    ST_RESPAWN   = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_lives;
  logic [2:0] w_lives_nxt;
  logic [7:0] r_timer;
  logic [7:0] w_timer_nxt;
  logic       r_ship_en;
  logic       w_ship_en_nxt;
  logic       r_game_reset;
  logic       w_game_reset_nxt;

  logic       r_start_sync1;
  logic       r_start_sync2;
  logic       r_start_prev;
  logic       w_start_edge;

  assign w_start_edge = r_start_sync2 & ~r_start_prev;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_start_sync1 <= 1'b0;
      r_start_sync2 <= 1'b0;
      r_start_prev  <= 1'b0;
    end else begin
      r_start_sync1 <= iStart;
      r_start_sync2 <= r_start_sync1;
      r_start_prev  <= r_start_sync2;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state      <= ST_ATTRACT;
      r_lives      <= 3'd0;
      r_timer      <= 8'd0;
      r_ship_en    <= 1'b0;
      r_game_reset <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_timer      <= w_timer_nxt;
      r_ship_en    <= w_ship_en_nxt;
      r_game_reset <= w_game_reset_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_lives_nxt      = r_lives;
    w_timer_nxt      = r_timer;
    w_game_reset_nxt = 1'b0;
    case (r_state)
      ST_ATTRACT: begin
        if (w_start_edge) begin
          w_state_nxt      = ST_PLAYING;
          w_lives_nxt      = c_LIVES_INIT;
          w_game_reset_nxt = 1'b1;
        end
      end
      ST_PLAYING: begin
        // A hit wins over a coincident frame tick; the tick is simply dropped.
        if (iShipHit) begin
          if (r_lives > 3'd1) begin
            w_state_nxt = ST_RESPAWN;
            w_lives_nxt = r_lives - 3'd1;
            w_timer_nxt = c_RESPAWN_INIT;
          end else begin
            w_state_nxt = ST_GAME_OVER;
            w_lives_nxt = 3'd0;
            w_timer_nxt = c_HOLD_INIT;
          end
        end
      end
      ST_RESPAWN: begin
        if (iFrameTick) begin
          if (r_timer <= 8'd1) begin
            w_state_nxt = ST_PLAYING;
            w_timer_nxt = 8'd0;
          end else begin
            w_timer_nxt = r_timer - 8'd1;
          end
        end
      end
      ST_GAME_OVER: begin
        // Start is only honoured once the hold has fully expired.
        if (iFrameTick && (r_timer != 8'd0)) begin
          w_timer_nxt = r_timer - 8'd1;
        end else if (w_start_edge && (r_timer == 8'd0)) begin
          w_state_nxt      = ST_PLAYING;
          w_lives_nxt      = c_LIVES_INIT;
          w_game_reset_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_ATTRACT;
        w_lives_nxt = 3'd0;
        w_timer_nxt = 8'd0;
      end
    endcase
    w_ship_en_nxt = (w_state_nxt == ST_PLAYING);
  end

  assign oGameOver   = r_state;
  assign oLives      = r_lives;
  assign oShipEnable = r_ship_en;
  assign oGameReset  = r_game_reset;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_state_ctrl
// Purpose  : Directed self-checking bench for game_state_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_state_ctrl;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iStart;
  logic       iShipHit;
  logic       iFrameTick;
  logic [1:0] oGameOver;
  logic [2:0] oLives;
  logic       oShipEnable;
  logic       oGameReset;

  int n_checks = 0;
  int n_fail   = 0;

  game_state_ctrl #(
    .LIVES               (3),
    .RESPAWN_FRAMES      (4),
    .GAMEOVER_HOLD_FRAMES(6)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iStart     (iStart),
    .iShipHit   (iShipHit),
    .iFrameTick (iFrameTick),
    .oGameOver  (oGameOver),
    .oLives     (oLives),
    .oShipEnable(oShipEnable),
    .oGameReset (oGameReset)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] go, input logic [2:0] lv,
                         input logic se, input logic gr);
    check({tag, ".state"}, 8'(oGameOver), 8'(go));
    check({tag, ".lives"}, 8'(oLives), 8'(lv));
    check({tag, ".ship"},  8'(oShipEnable), 8'(se));
    check({tag, ".greset"}, 8'(oGameReset), 8'(gr));
  endtask

  task automatic clk1();
    @(posedge iClk);
    #1;
  endtask

  task automatic hit();
    iShipHit = 1'b1;
    clk1();
    iShipHit = 1'b0;
  endtask

  task automatic tick();
    iFrameTick = 1'b1;
    clk1();
    iFrameTick = 1'b0;
  endtask

  // Raise start; the synchronised edge takes effect on the third clock.
  task automatic press_start();
    iStart = 1'b1;
    clk1();
    clk1();
    clk1();
  endtask

  task automatic release_start();
    iStart = 1'b0;
    clk1();
    clk1();
    clk1();
  endtask

  initial begin
    int pulses;
    iRst = 1'b0; iStart = 1'b0; iShipHit = 1'b0; iFrameTick = 1'b0;
    repeat (3) clk1();
    chk_all("rst", 2'b10, 3'd0, 1'b0, 1'b0);
    iRst = 1'b1;
    hit();
    tick();
    chk_all("attract_ignore", 2'b10, 3'd0, 1'b0, 1'b0);

    // New game from ATTRACT: two-flop sync plus edge detect latency.
    iStart = 1'b1;
    clk1();
    check("start_n", 8'(oGameOver), 8'h2);
    clk1();
    check("start_n1", 8'(oGameOver), 8'h2);
    clk1();
    chk_all("start_n2", 2'b00, 3'd3, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      clk1();
      if (oGameReset) pulses++;
    end
    check("held_start_pulses", 8'(pulses), 8'd0);
    check("held_start_state", 8'(oGameOver), 8'h0);
    release_start();

    // Non-fatal hit, hits ignored while respawning, exact 4-tick respawn.
    hit();
    chk_all("hit1", 2'b11, 3'd2, 1'b0, 1'b0);
    hit();
    check("respawn_hit_lives", 8'(oLives), 8'd2);
    tick(); tick(); tick();
    check("respawn_t3", 8'(oGameOver), 8'h3);
    hit();
    check("respawn_hit2_lives", 8'(oLives), 8'd2);
    tick();
    chk_all("respawn_done", 2'b00, 3'd2, 1'b1, 1'b0);

    // Hit and tick together: the tick must not count toward respawn.
    iShipHit = 1'b1; iFrameTick = 1'b1;
    clk1();
    iShipHit = 1'b0; iFrameTick = 1'b0;
    chk_all("hit_tick", 2'b11, 3'd1, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("hit_tick_t3", 8'(oGameOver), 8'h3);
    tick();
    chk_all("hit_tick_t4", 2'b00, 3'd1, 1'b1, 1'b0);

    // Last life lost, early start discarded, restart after hold expires.
    hit();
    chk_all("gameover", 2'b01, 3'd0, 1'b0, 1'b0);
    tick(); tick(); tick();
    press_start();
    chk_all("early_start", 2'b01, 3'd0, 1'b0, 1'b0);
    release_start();
    tick(); tick(); tick();
    tick();
    check("hold_sat", 8'(oGameOver), 8'h1);
    press_start();
    chk_all("restart", 2'b00, 3'd3, 1'b1, 1'b1);
    clk1();
    check("restart_pulse_end", 8'(oGameReset), 8'd0);
    release_start();

    hit();
    chk_all("seq_hit1", 2'b11, 3'd2, 1'b0, 1'b0);
    repeat (4) tick();
    hit();
    chk_all("seq_hit2", 2'b11, 3'd1, 1'b0, 1'b0);
    repeat (4) tick();
    check("seq_play", 8'(oGameOver), 8'h0);
    hit();
    chk_all("seq_hit3", 2'b01, 3'd0, 1'b0, 1'b0);

    // Hold down to 1, then start coincident with the final tick.
    repeat (5) tick();
    iStart = 1'b1;
    clk1();
    clk1();
    iFrameTick = 1'b1;
    clk1();
    iFrameTick = 1'b0;
    chk_all("start_tick_t1", 2'b01, 3'd0, 1'b0, 1'b0);
    repeat (3) clk1();
    check("held_no_retrigger", 8'(oGameOver), 8'h1);
    release_start();
    press_start();
    chk_all("start_after_zero", 2'b00, 3'd3, 1'b1, 1'b1);
    release_start();

    // Async reset mid-respawn with timer at 2.
    hit();
    tick(); tick();
    check("pre_rst_state", 8'(oGameOver), 8'h3);
    #2;
    iRst = 1'b0;
    #1;
    chk_all("async_rst", 2'b10, 3'd0, 1'b0, 1'b0);
    clk1();
    chk_all("async_rst_hold", 2'b10, 3'd0, 1'b0, 1'b0);
    iRst = 1'b1;
    clk1();
    check("post_rst_attract", 8'(oGameOver), 8'h2);
    press_start();
    chk_all("post_rst_start", 2'b00, 3'd3, 1'b1, 1'b1);
    clk1();
    check("post_rst_pulse_end", 8'(oGameReset), 8'd0);
    release_start();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
